// File: rtl/rv32i_mc_top.sv
// rtl/rv32i_mc_top.sv - multi-cycle RV32I core on a shared req/ready memory bus
// Optional RV32I_MC_COUNTERS_EN adds 64-bit mcycle/minstret CSRs.
module rv32i_mc_top #(
    parameter logic [31:0] RESET_VECTOR = 32'h8000_0000,
    parameter int          MAX_WAIT     = 16,
    parameter int          WAIT_CNT_W   = $clog2(MAX_WAIT + 1)
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        retire,
    output logic        halted,
    output logic [1:0]  fault
);
    localparam int CW = (WAIT_CNT_W < 1) ? 1 : WAIT_CNT_W;

    typedef enum logic [2:0] {FETCH, EXEC, MEM, WB, HALT} state_t;
    state_t state, state_n;
    logic [1:0]    fault_n;
    logic [31:0]   pc, instr, ld_data, next_pc;
    logic          armed;
    logic [CW-1:0] wait_cnt;
    logic [31:0]   regs [32];
    logic [31:0]   mtvec, mscratch, mepc, csr_data, csr_src, csr_wval;

    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [11:0] csr_addr;
    logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_opi, is_op;
    logic is_csr, is_mret, r_we, br_taken, mis_data, timeout;
    logic [31:0] imm, rs1_data, rs2_data, alu_a, alu_b, alu_result, ea, rd_data, ld_ext;

    assign rd       = instr[11:7];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign funct3   = instr[14:12];
    assign csr_addr = instr[31:20];
    assign is_lui   = instr[6:0] == 7'h37;
    assign is_auipc = instr[6:0] == 7'h17;
    assign is_jal   = instr[6:0] == 7'h6F;
    assign is_jalr  = instr[6:0] == 7'h67;
    assign is_br    = instr[6:0] == 7'h63;
    assign is_ld    = instr[6:0] == 7'h03;
    assign is_st    = instr[6:0] == 7'h23;
    assign is_opi   = instr[6:0] == 7'h13;
    assign is_op    = instr[6:0] == 7'h33;
    assign is_csr   = (instr[6:0] == 7'h73) && (funct3[1:0] != 2'b00);
    assign is_mret  = instr == 32'h3020_0073;
    assign r_we     = is_lui | is_auipc | is_jal | is_jalr | is_ld | is_opi | is_op | is_csr;
    assign rs1_data = (rs1 == 5'd0) ? 32'h0 : regs[rs1];
    assign rs2_data = (rs2 == 5'd0) ? 32'h0 : regs[rs2];
    assign ea       = alu_result;
    assign mis_data = (funct3[1:0] == 2'b01 && ea[0]) || (funct3[1:0] == 2'b10 && ea[1:0] != 2'b00);
    assign timeout  = (MAX_WAIT != 0) && mem_req && !mem_ready && (wait_cnt == CW'(MAX_WAIT - 1));

    always_comb begin
        imm = {{20{instr[31]}}, instr[31:20]};
        if (is_st)                  imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        else if (is_br)             imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        else if (is_lui | is_auipc) imm = {instr[31:12], 12'h0};
        else if (is_jal)            imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    end

    always_comb begin
        alu_a = is_auipc ? pc : (is_lui ? 32'h0 : rs1_data);
        alu_b = (is_op | is_br) ? rs2_data : imm;
        alu_result = alu_a + alu_b;
        if (is_op | is_opi) begin
            case (funct3)
                3'b000:  alu_result = (is_op && instr[30]) ? alu_a - alu_b : alu_a + alu_b;
                3'b001:  alu_result = alu_a << alu_b[4:0];
                3'b010:  alu_result = {31'h0, $signed(alu_a) < $signed(alu_b)};
                3'b011:  alu_result = {31'h0, alu_a < alu_b};
                3'b100:  alu_result = alu_a ^ alu_b;
                3'b101:  alu_result = instr[30] ? 32'($signed(alu_a) >>> alu_b[4:0]) : alu_a >> alu_b[4:0];
                3'b110:  alu_result = alu_a | alu_b;
                default: alu_result = alu_a & alu_b;
            endcase
        end
    end

    always_comb begin
        case (funct3)
            3'b000:  br_taken = rs1_data == rs2_data;
            3'b001:  br_taken = rs1_data != rs2_data;
            3'b100:  br_taken = $signed(rs1_data) < $signed(rs2_data);
            3'b101:  br_taken = $signed(rs1_data) >= $signed(rs2_data);
            3'b110:  br_taken = rs1_data < rs2_data;
            3'b111:  br_taken = rs1_data >= rs2_data;
            default: br_taken = 1'b0;
        endcase
    end

`ifdef RV32I_MC_COUNTERS_EN
    logic [63:0] mcycle, minstret;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mcycle   <= 64'h0;
            minstret <= 64'h0;
        end else begin
            mcycle <= mcycle + 64'd1;
            if (retire) minstret <= minstret + 64'd1;
        end
    end
`endif

    // Counter addresses are read-only overlays on top of the CSR file
    always_comb begin
        case (csr_addr)
            12'h305: csr_data = mtvec;
            12'h340: csr_data = mscratch;
            12'h341: csr_data = mepc;
            default: csr_data = 32'h0;
        endcase
`ifdef RV32I_MC_COUNTERS_EN
        case (csr_addr)
            12'hB00: csr_data = mcycle[31:0];
            12'hB80: csr_data = mcycle[63:32];
            12'hB02: csr_data = minstret[31:0];
            12'hB82: csr_data = minstret[63:32];
            default: ;
        endcase
`endif
    end

    always_comb begin
        csr_src = funct3[2] ? {27'h0, rs1} : rs1_data;
        case (funct3[1:0])
            2'b10:   csr_wval = csr_data | csr_src;
            2'b11:   csr_wval = csr_data & ~csr_src;
            default: csr_wval = csr_src;
        endcase
        case (funct3)
            3'b000:  ld_ext = {{24{ld_data[7]}}, ld_data[7:0]};
            3'b001:  ld_ext = {{16{ld_data[15]}}, ld_data[15:0]};
            3'b100:  ld_ext = {24'h0, ld_data[7:0]};
            3'b101:  ld_ext = {16'h0, ld_data[15:0]};
            default: ld_ext = ld_data;
        endcase
        if (is_ld)                rd_data = ld_ext;
        else if (is_jal | is_jalr) rd_data = pc + 32'd4;
        else if (is_csr)          rd_data = csr_data;
        else                      rd_data = alu_result;
        if ((is_br && br_taken) || is_jal) next_pc = pc + imm;
        else if (is_jalr)                  next_pc = {alu_result[31:1], 1'b0};
        else if (is_mret)                  next_pc = mepc;
        else                               next_pc = pc + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= FETCH;
            fault <= 2'd0;
        end else begin
            state <= state_n;
            fault <= fault_n;
        end
    end

    always_comb begin
        state_n = state;
        fault_n = fault;
        case (state)
            FETCH: begin
                if (pc[1:0] != 2'b00) begin
                    state_n = HALT;
                    fault_n = 2'd1;
                end else if (mem_req && mem_ready) begin
                    state_n = EXEC;
                end else if (timeout) begin
                    state_n = HALT;
                    fault_n = 2'd3;
                end
            end
            EXEC: state_n = (is_ld | is_st) ? MEM : WB;
            MEM: begin
                if (mis_data) begin
                    state_n = HALT;
                    fault_n = 2'd2;
                end else if (mem_req && mem_ready) begin
                    state_n = WB;
                end else if (timeout) begin
                    state_n = HALT;
                    fault_n = 2'd3;
                end
            end
            WB:      state_n = FETCH;
            default: state_n = HALT;
        endcase
    end

    // Request fields depend only on registered state, so they hold steady while waiting
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_wstrb = 4'b0000;
        retire    = state == WB;
        halted    = state == HALT;
        case (state)
            FETCH: if (armed && pc[1:0] == 2'b00) begin
                mem_req  = 1'b1;
                mem_addr = pc;
            end
            MEM: if (!mis_data) begin
                mem_req  = 1'b1;
                mem_addr = {ea[31:2], 2'b00};
                if (is_st) begin
                    mem_we    = 1'b1;
                    mem_wdata = rs2_data << {ea[1:0], 3'b000};
                    case (funct3[1:0])
                        2'b00:   mem_wstrb = 4'b0001 << ea[1:0];
                        2'b01:   mem_wstrb = 4'b0011 << ea[1:0];
                        default: mem_wstrb = 4'b1111;
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc       <= RESET_VECTOR;
            instr    <= 32'h0000_0013;
            ld_data  <= 32'h0;
            armed    <= 1'b0;
            wait_cnt <= '0;
            mtvec    <= 32'h0;
            mscratch <= 32'h0;
            mepc     <= 32'h0;
        end else begin
            armed <= 1'b1;
            if (mem_req && mem_ready) wait_cnt <= '0;
            else if (mem_req)         wait_cnt <= wait_cnt + CW'(1);
            if (state == FETCH && mem_req && mem_ready) instr <= mem_rdata;
            if (state == MEM && mem_req && mem_ready && !mem_we) ld_data <= mem_rdata >> {ea[1:0], 3'b000};
            if (state == WB) begin
                pc <= next_pc;
                if (is_csr) begin
                    case (csr_addr)
                        12'h305: mtvec    <= csr_wval;
                        12'h340: mscratch <= csr_wval;
                        12'h341: mepc     <= csr_wval;
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && state == WB && r_we && rd != 5'd0) regs[rd] <= rd_data;
    end
endmodule

// File: tb/tb_rv32i_mc_top.sv
// tb/tb_rv32i_mc_top.sv - directed self-checking bench for rv32i_mc_top
module tb_rv32i_mc_top;
    localparam logic [31:0] B = 32'h8000_0000;
    localparam logic [31:0] D = 32'h8000_1000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mem_req, mem_we, mem_ready, retire, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic [1:0]  fault;

    rv32i_mc_top dut (
        .clk(clk), .reset_n(reset_n), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .retire(retire),
        .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } txn_t;

    int          n_checks = 0;
    int          n_fail = 0;
    int          wait_n = 0;
    int          unstable = 0;
    logic [31:0] mem [0:2047];
    txn_t        log_q[$];
    txn_t        exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    // Bus responder: inserts wait_n idle cycles per request and logs accepted transfers
    initial begin
        bit          busy = 0;
        int          wcnt = 0;
        txn_t        h;
        logic [10:0] idx;
        mem_ready = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                if (!busy) begin
                    busy = 1;
                    wcnt = 0;
                    h = '{mem_addr, mem_we, mem_wstrb, mem_wdata};
                end else if (h.addr !== mem_addr || h.we !== mem_we ||
                             h.wstrb !== mem_wstrb || h.wdata !== mem_wdata) begin
                    unstable++;
                end
                if (wcnt >= wait_n) begin
                    idx = mem_addr[12:2];
                    mem_ready = 1'b1;
                    mem_rdata = mem[idx];
                    if (mem_we)
                        for (int b = 0; b < 4; b++)
                            if (mem_wstrb[b]) mem[idx][8*b +: 8] = mem_wdata[8*b +: 8];
                    log_q.push_back(h);
                    busy = 0;
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = 32'hDEAD_BEEF;
                    wcnt++;
                end
            end else begin
                busy = 0;
                mem_ready = 1'b0;
                mem_rdata = 32'hDEAD_BEEF;
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
        log_q.delete();
        exp_q.delete();
    endtask

    task automatic hold_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic run(input int budget, output int c_req, output int c_ret, output int n_ret,
                       output logic [31:0] a_req, output logic we_req, output bit timed_out);
        c_req = 0; c_ret = 0; n_ret = 0; a_req = 32'h0; we_req = 1'b0; timed_out = 1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (mem_req && c_req == 0) begin
                c_req = c;
                a_req = mem_addr;
                we_req = mem_we;
            end
            if (retire) begin
                n_ret++;
                if (c_ret == 0) c_ret = c;
            end
            if (halted) begin
                timed_out = 0;
                break;
            end
        end
    endtask

    task automatic ex(input logic [31:0] addr, input logic we, input logic [3:0] strb, input logic [31:0] wd);
        exp_q.push_back('{addr, we, strb, wd});
    endtask

    task automatic compare_log(input string name);
        check_eq({name, "_txn_count"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            check_eq($sformatf("%s_txn%0d_addr", name, i), log_q[i].addr, exp_q[i].addr);
            check_eq($sformatf("%s_txn%0d_we", name, i), {31'h0, log_q[i].we}, {31'h0, exp_q[i].we});
            check_eq($sformatf("%s_txn%0d_wstrb", name, i), {28'h0, log_q[i].wstrb}, {28'h0, exp_q[i].wstrb});
            if (exp_q[i].we)
                check_eq($sformatf("%s_txn%0d_wdata", name, i), log_q[i].wdata, exp_q[i].wdata);
        end
    endtask

    initial begin
        int          c_req, c_ret, n_ret, n_req;
        logic [31:0] a_req;
        logic        we_req;
        bit          to;
        bit          seen;

        // Test 1: zero-wait program covering stores, loads, branches and a data misalign fault
        clear_mem();
        mem[0]  = enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13);
        mem[1]  = {20'h80001, 5'd2, 7'h37};
        mem[2]  = enc_i(12'd1, 5'd2, 3'd0, 5'd2, 7'h13);
        mem[3]  = enc_i(12'hA5, 5'd0, 3'd0, 5'd3, 7'h13);
        mem[4]  = enc_s(12'd0, 5'd3, 5'd2, 3'd0);
        mem[5]  = enc_s(12'd3, 5'd1, 5'd2, 3'd2);
        mem[6]  = enc_i(12'd0, 5'd2, 3'd0, 5'd4, 7'h03);
        mem[7]  = enc_s(12'd7, 5'd4, 5'd2, 3'd2);
        mem[8]  = enc_i(12'd0, 5'd2, 3'd4, 5'd4, 7'h03);
        mem[9]  = enc_s(12'd11, 5'd4, 5'd2, 3'd2);
        mem[10] = enc_i(12'd7, 5'd0, 3'd0, 5'd5, 7'h13);
        mem[11] = enc_b(13'd8, 5'd0, 5'd0, 3'd0);
        mem[12] = enc_i(12'd1, 5'd0, 3'd0, 5'd5, 7'h13);
        mem[13] = enc_b(13'd8, 5'd0, 5'd0, 3'd1);
        mem[14] = enc_s(12'd15, 5'd5, 5'd2, 3'd2);
        mem[15] = enc_i(12'd1, 5'd2, 3'd2, 5'd6, 7'h03);
        wait_n = 0;
        @(negedge clk);
        hold_reset();
        check_eq("rst_mem_req", {31'h0, mem_req}, 32'h0);
        check_eq("rst_retire", {31'h0, retire}, 32'h0);
        check_eq("rst_halted", {31'h0, halted}, 32'h0);
        check_eq("rst_fault", {30'h0, fault}, 32'h0);
        reset_n = 1'b1;
        run(400, c_req, c_ret, n_ret, a_req, we_req, to);
        check_eq("t1_no_timeout", {31'h0, to}, 32'h0);
        check_eq("t1_first_addr", a_req, B);
        check_eq("t1_first_we", {31'h0, we_req}, 32'h0);
        check_eq("t1_first_retire_cycle", c_ret - c_req + 1, 32'd3);
        check_eq("t1_retired", n_ret, 32'd14);
        check_eq("t1_halted", {31'h0, halted}, 32'h1);
        check_eq("t1_fault", {30'h0, fault}, 32'h2);
        repeat (3) @(negedge clk);
        check_eq("t1_halt_req", {31'h0, mem_req}, 32'h0);
        for (int i = 0; i <= 4; i++) ex(B + 32'(4 * i), 1'b0, 4'h0, 32'h0);
        ex(D, 1'b1, 4'b0010, 32'h0000_A500);
        ex(B + 32'h14, 1'b0, 4'h0, 32'h0);
        ex(D + 32'h4, 1'b1, 4'hF, 32'h0000_0005);
        ex(B + 32'h18, 1'b0, 4'h0, 32'h0);
        ex(D, 1'b0, 4'h0, 32'h0);
        ex(B + 32'h1C, 1'b0, 4'h0, 32'h0);
        ex(D + 32'h8, 1'b1, 4'hF, 32'hFFFF_FFA5);
        ex(B + 32'h20, 1'b0, 4'h0, 32'h0);
        ex(D, 1'b0, 4'h0, 32'h0);
        ex(B + 32'h24, 1'b0, 4'h0, 32'h0);
        ex(D + 32'hC, 1'b1, 4'hF, 32'h0000_00A5);
        ex(B + 32'h28, 1'b0, 4'h0, 32'h0);
        ex(B + 32'h2C, 1'b0, 4'h0, 32'h0);
        ex(B + 32'h34, 1'b0, 4'h0, 32'h0);
        ex(B + 32'h38, 1'b0, 4'h0, 32'h0);
        ex(D + 32'h10, 1'b1, 4'hF, 32'h0000_0007);
        ex(B + 32'h3C, 1'b0, 4'h0, 32'h0);
        compare_log("t1");

        // Test 2: three wait cycles per request, then a jump to a misaligned pc
        clear_mem();
        mem[0] = enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13);
        mem[1] = enc_j(21'd6, 5'd0);
        wait_n = 3;
        unstable = 0;
        hold_reset();
        reset_n = 1'b1;
        run(100, c_req, c_ret, n_ret, a_req, we_req, to);
        check_eq("t2_no_timeout", {31'h0, to}, 32'h0);
        check_eq("t2_first_retire_cycle", c_ret - c_req + 1, 32'd6);
        check_eq("t2_req_stable", unstable, 32'd0);
        check_eq("t2_retired", n_ret, 32'd2);
        check_eq("t2_fault", {30'h0, fault}, 32'h1);
        ex(B, 1'b0, 4'h0, 32'h0);
        ex(B + 32'h4, 1'b0, 4'h0, 32'h0);
        compare_log("t2");

        // Test 3: memory never ready -> watchdog fault after 16 waiting cycles
        wait_n = 1000;
        hold_reset();
        reset_n = 1'b1;
        n_req = 0;
        seen = 0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clk);
            if (mem_req) n_req++;
            if (halted) seen = 1;
        end
        check_eq("t3_halt_seen", {31'h0, seen}, 32'h1);
        check_eq("t3_wait_cycles", n_req, 32'd16);
        check_eq("t3_req_dropped", {31'h0, mem_req}, 32'h0);
        check_eq("t3_fault", {30'h0, fault}, 32'h3);

        // Test 4: reset during a pending fetch, then refetch from the reset vector
        hold_reset();
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("t4_pending_req", {31'h0, mem_req}, 32'h1);
        reset_n = 1'b0;
        @(negedge clk);
        check_eq("t4_req_after_reset", {31'h0, mem_req}, 32'h0);
        check_eq("t4_halted_cleared", {31'h0, halted}, 32'h0);
        check_eq("t4_fault_cleared", {30'h0, fault}, 32'h0);
        wait_n = 0;
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        a_req = 32'h0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (mem_req) begin
                seen = 1;
                a_req = mem_addr;
            end
        end
        check_eq("t4_refetch_seen", {31'h0, seen}, 32'h1);
        check_eq("t4_refetch_addr", a_req, B);

`ifdef RV32I_MC_COUNTERS_EN
        // Test 5: minstret reads 3 after three retired instructions
        clear_mem();
        mem[0] = enc_i(12'd1, 5'd0, 3'd0, 5'd1, 7'h13);
        mem[1] = enc_i(12'd2, 5'd0, 3'd0, 5'd1, 7'h13);
        mem[2] = {20'h80001, 5'd2, 7'h37};
        mem[3] = enc_i(12'hB02, 5'd0, 3'd2, 5'd7, 7'h73);
        mem[4] = enc_s(12'd0, 5'd7, 5'd2, 3'd2);
        mem[5] = enc_i(12'd2, 5'd2, 3'd2, 5'd6, 7'h03);
        hold_reset();
        reset_n = 1'b1;
        run(200, c_req, c_ret, n_ret, a_req, we_req, to);
        check_eq("t5_fault", {30'h0, fault}, 32'h2);
        for (int i = 0; i <= 4; i++) ex(B + 32'(4 * i), 1'b0, 4'h0, 32'h0);
        ex(D, 1'b1, 4'hF, 32'd3);
        ex(B + 32'h14, 1'b0, 4'h0, 32'h0);
        compare_log("t5");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
